// File: rtl/seg7_pkg.sv
// seg7_pkg: shared codes and active-low segment patterns for the seven-segment scan driver.
//   Patterns are 7 bits, [0]=a .. [6]=g, 0 = segment lit.
package seg7_pkg;
  localparam logic [3:0] SEG7_CODE_DASH  = 4'hE;
  localparam logic [3:0] SEG7_CODE_BLANK = 4'hF;
  localparam logic [7:0] SEG7_OFF        = 8'hFF;
  localparam logic [6:0] SEG7_PAT_0      = 7'h40;
  localparam logic [6:0] SEG7_PAT_1      = 7'h79;
  localparam logic [6:0] SEG7_PAT_2      = 7'h24;
  localparam logic [6:0] SEG7_PAT_3      = 7'h30;
  localparam logic [6:0] SEG7_PAT_4      = 7'h19;
  localparam logic [6:0] SEG7_PAT_5      = 7'h12;
  localparam logic [6:0] SEG7_PAT_6      = 7'h02;
  localparam logic [6:0] SEG7_PAT_7      = 7'h78;
  localparam logic [6:0] SEG7_PAT_8      = 7'h00;
  localparam logic [6:0] SEG7_PAT_9      = 7'h10;
  localparam logic [6:0] SEG7_PAT_A      = 7'h08;
  localparam logic [6:0] SEG7_PAT_B      = 7'h03;
  localparam logic [6:0] SEG7_PAT_C      = 7'h46;
  localparam logic [6:0] SEG7_PAT_D      = 7'h21;
  localparam logic [6:0] SEG7_PAT_DASH   = 7'h3F;
  localparam logic [6:0] SEG7_PAT_BLANK  = 7'h7F;
  // Full active-low segment byte: decimal point in bit 7.
  function automatic logic [7:0] seg7_pack(input logic [6:0] pat, input logic dp);
    return {~dp, pat};
  endfunction
endpackage

// File: rtl/seg7_scan_driver_decode.sv
// seg7_decode: combinational nibble -> active-low 7-segment pattern.
//   code  in  4  digit code (0-9, A-d, E=dash, F=blank)
//   pat   out 7  [0]=a .. [6]=g, active-low
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pat
);
  always_comb
    case (code)
      4'h0:            pat = SEG7_PAT_0;
      4'h1:            pat = SEG7_PAT_1;
      4'h2:            pat = SEG7_PAT_2;
      4'h3:            pat = SEG7_PAT_3;
      4'h4:            pat = SEG7_PAT_4;
      4'h5:            pat = SEG7_PAT_5;
      4'h6:            pat = SEG7_PAT_6;
      4'h7:            pat = SEG7_PAT_7;
      4'h8:            pat = SEG7_PAT_8;
      4'h9:            pat = SEG7_PAT_9;
      4'hA:            pat = SEG7_PAT_A;
      4'hB:            pat = SEG7_PAT_B;
      4'hC:            pat = SEG7_PAT_C;
      4'hD:            pat = SEG7_PAT_D;
      SEG7_CODE_DASH:  pat = SEG7_PAT_DASH;
      default:         pat = SEG7_PAT_BLANK;
    endcase
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed common-anode 8-digit seven-segment driver with per-frame snapshot.
//   clk_50mhz in  system clock      rst        in  sync active-high reset
//   digits_in in  4*NUM_DIGITS      dp_in      in  NUM_DIGITS, 1 = dp lit
//   blank_in  in  NUM_DIGITS        dim_level  in  3 (only with SEG7_DIM_EN)
//   seg_n     out 8 active-low      an_n       out NUM_DIGITS active-low
//   frame_done out one-cycle pulse when a new snapshot is taken
//   Define SEG7_DIM_EN to add PWM dimming of the lit window.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic                    clk_50mhz,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
`ifdef SEG7_DIM_EN
  input  logic [2:0]              dim_level,
`endif
  output logic [7:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] DEAD    = CW'(DEAD_CYCLES);
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_blank;
  logic [3:0]              code;
  logic [6:0]              pat;
  logic                    wrap;
  logic                    boundary;
  logic                    dark;
  logic                    dim_ok;
  logic                    lit;
  assign wrap     = cnt == CNT_MAX;
  assign boundary = wrap && idx == IDX_MAX;
  assign code     = snap_digits[{idx, 2'b00} +: 4];
  // A blank code also keeps the anode off, so the reset snapshot shows a fully dark frame.
  assign dark     = snap_blank[idx] || code == SEG7_CODE_BLANK;
  assign lit      = cnt >= DEAD && !dark && dim_ok;
`ifdef SEG7_DIM_EN
  logic [2:0] pwm;
  logic [2:0] snap_dim;
  always_ff @(posedge clk_50mhz)
    if (rst) begin
      pwm      <= '0;
      snap_dim <= 3'd7;
    end else begin
      pwm <= pwm + 1'b1;
      if (boundary) snap_dim <= dim_level;
    end
  assign dim_ok = pwm <= snap_dim;
`else
  assign dim_ok = 1'b1;
`endif
  seg7_decode u_dec (
    .code (code),
    .pat  (pat)
  );
  always_ff @(posedge clk_50mhz)
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      snap_digits <= '1;
      snap_dp     <= '0;
      snap_blank  <= '0;
      seg_n       <= SEG7_OFF;
      an_n        <= '1;
      frame_done  <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= idx == IDX_MAX ? '0 : idx + 1'b1;
      if (boundary) {snap_digits, snap_dp, snap_blank} <= {digits_in, dp_in, blank_in};
      seg_n      <= dark ? SEG7_OFF : seg7_pack(pat, snap_dp[idx]);
      an_n       <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
      frame_done <= boundary;
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard plus directed checks for seg7_scan_driver (SCAN_DIV=10, DEAD_CYCLES=2).
module tb_seg7_scan_driver;
  localparam int ND = 8;
  localparam int SD = 10;
  localparam int DC = 2;
  typedef struct packed {
    logic [7:0] seg;
    logic [7:0] an;
    logic       fd;
  } exp_t;
  logic        clk_50mhz = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] digits_in = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  blank_in = '0;
  logic [2:0]  dim_level = 3'd7;
  logic [7:0]  seg_n;
  logic [7:0]  an_n;
  logic        frame_done;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  logic [7:0]  pat_lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'hBF, 8'hFF};
  always #10 clk_50mhz = ~clk_50mhz;
  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYCLES(DC)) dut (
    .clk_50mhz  (clk_50mhz),
    .rst        (rst),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
`ifdef SEG7_DIM_EN
    .dim_level  (dim_level),
`endif
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // Reference model: t = cycles since reset release; slot/phase derived by division.
  int         t;
  logic [31:0] m_dig;
  logic [7:0]  m_dp, m_bl;
  logic [2:0]  m_dim, m_pwm;
  always @(posedge clk_50mhz) begin
    exp_t       e;
    int         slot, phase;
    logic [3:0] nib;
    logic       drk;
    if (rst) begin
      e = '{seg: 8'hFF, an: 8'hFF, fd: 1'b0};
      t = 0; m_dig = '1; m_dp = '0; m_bl = '0; m_dim = 3'd7; m_pwm = '0;
    end else begin
      slot  = (t / SD) % ND;
      phase = t % SD;
      nib   = m_dig[slot*4 +: 4];
      drk   = m_bl[slot] || nib == 4'hF;
      e.seg = drk ? 8'hFF : {~m_dp[slot], pat_lut[nib][6:0]};
      e.an  = (phase >= DC && !drk && m_pwm <= m_dim) ? ~(8'b1 << slot) : 8'hFF;
      e.fd  = phase == SD - 1 && slot == ND - 1;
      if (e.fd) begin m_dig = digits_in; m_dp = dp_in; m_bl = blank_in; m_dim = dim_level; end
      t++;
      m_pwm = m_pwm + 3'd1;
    end
    sb.push_back(e);
  end
  always @(negedge clk_50mhz)
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("sb_an_n", an_n, e.an);
      check("sb_seg_n", seg_n, e.seg);
      check("sb_frame_done", frame_done, e.fd);
    end
  task automatic step(input int k);
    repeat (k) @(negedge clk_50mhz);
  endtask
  task automatic wait_frame(output int n);
    n = 0;
    do begin @(negedge clk_50mhz); n++; end while (!frame_done && n < 200);
    if (!frame_done) check("frame_timeout", 0, 1);
  endtask
  task automatic count_lit(input int k, input int bit_i, output int c);
    c = 0;
    repeat (k) begin @(negedge clk_50mhz); if (an_n[bit_i] === 1'b0) c++; end
  endtask
  initial begin
    int n, c;
    repeat (3) @(posedge clk_50mhz);
    @(negedge clk_50mhz);
    check("rst_an_n", an_n, 8'hFF);
    check("rst_seg_n", seg_n, 8'hFF);
    check("rst_frame_done", frame_done, 0);
    rst = 1'b0;
    digits_in = 32'h15E30E42;
    c = 0;
    repeat (79) begin @(negedge clk_50mhz); if (an_n !== 8'hFF || seg_n !== 8'hFF) c++; end
    check("first_frame_dark", c, 0);
    wait_frame(n);
    check("first_frame_len", n, 1);
    step(1); check("s0_dead_an", an_n, 8'hFF); check("s0_dead_seg", seg_n, 8'hA4);
    step(1); check("s0_dead2_an", an_n, 8'hFF);
    step(1); check("s0_lit_an", an_n, 8'hFE); check("s0_lit_seg", seg_n, 8'hA4);
    count_lit(7, 0, c); check("s0_lit_count", c, 7);
    step(15); check("s2_an", an_n, 8'hFB); check("s2_seg", seg_n, 8'hBF);
    digits_in = 32'h00000001;
    step(10); check("s3_unchanged_an", an_n, 8'hF7); check("s3_unchanged_seg", seg_n, 8'hC0);
    wait_frame(n);
    check("frame_period", n, 45);
    step(5);  check("new_s0_seg", seg_n, 8'hF9); check("new_s0_an", an_n, 8'hFE);
    step(10); check("new_s1_seg", seg_n, 8'hC0); check("new_s1_an", an_n, 8'hFD);
    dp_in = 8'h04; blank_in = 8'h80;
    wait_frame(n);
    step(25); check("s2_dp_bit", seg_n[7], 0); check("s2_dp_seg", seg_n, 8'h40);
    step(45);
    c = 0;
    repeat (10) begin @(negedge clk_50mhz); if (an_n !== 8'hFF) c++; end
    check("s7_blank_slot", c, 0);
    wait_frame(n);
    step(35);
    rst = 1'b1;
    @(negedge clk_50mhz);
    check("midrst_an_n", an_n, 8'hFF);
    check("midrst_seg_n", seg_n, 8'hFF);
    rst = 1'b0;
    wait_frame(n);
    check("midrst_frame_len", n, 80);
`ifdef SEG7_DIM_EN
    dim_level = 3'd3;
    wait_frame(n); wait_frame(n);
    step(2); count_lit(8, 0, c); check("dim3_duty", c, 4);
    dim_level = 3'd7;
    wait_frame(n); wait_frame(n);
    step(2); count_lit(8, 0, c); check("dim7_duty", c, 8);
`endif
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
